// File: rtl/fpga_endpoint_uart_tx.sv
// -----------------------------------------------------------------------------
// fpga_endpoint_uart_tx
//
// UART 8N1 transmitter that returns bus responses to the host. One response
// (status + read data) is taken through a valid/ready handshake. It is sent
// as a status byte (8'h00 ok, 8'h01 error) followed by NUM_BYTES data bytes,
// least-significant byte first. Each byte is framed as start(0), 8 data bits
// LSB first, stop(1). Every line bit lasts CLKDIV = FREQUENCY / BAUD_RATE
// clock cycles.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   rsp_valid  in   response available
//   rsp_ready  out  block can accept a response (idle)
//   rsp_error  in   bus error flag, sampled on accept
//   rsp_data   in   read data (NUM_BYTES*8 bits), sampled on accept
//   serial_out out  UART line, idle high (registered)
//   busy       out  frame in progress
//   done       out  one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module fpga_endpoint_uart_tx #(
    parameter int FREQUENCY = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rsp_valid,
    output logic                   rsp_ready,
    input  logic                   rsp_error,
    input  logic [NUM_BYTES*8-1:0] rsp_data,
    output logic                   serial_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CLKDIV  = FREQUENCY / BAUD_RATE;
    localparam int CNT_W   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BYTE_W  = $clog2(NUM_BYTES + 1);
    localparam int FRAME_W = (NUM_BYTES + 1) * 8;

    // A bit period of a single cycle cannot be built with this counter scheme.
    generate
        if (CLKDIV < 2) begin : g_bad_clkdiv
            $error("fpga_endpoint_uart_tx: FREQUENCY / BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]    byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 serial_out_q, serial_out_d;
    logic                 tick;
    logic [7:0]           next_byte;

    // Last cycle of the current line bit.
    assign tick = (cnt_q == CNT_W'(CLKDIV - 1));

    // Next-state logic. The whole response is latched into frame_q on accept
    // with the status byte in the low byte; after each stop bit the register
    // shifts down one byte, so the byte on the line is always frame_q[7:0].
    // The line itself is registered from the next state so serial_out is
    // glitch-free and the start bit appears the cycle after the accept edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        frame_d      = frame_q;
        done         = 1'b0;
        serial_out_d = 1'b1;
        next_byte    = 8'h00;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rsp_valid) begin
                    frame_d    = {rsp_data, 7'b0, rsp_error};
                    cnt_d      = '0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx_q == BYTE_W'(NUM_BYTES)) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        frame_d    = frame_q >> 8;
                        state_d    = START;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        next_byte = frame_d[7:0];
        case (state_d)
            IDLE:    serial_out_d = 1'b1;
            START:   serial_out_d = 1'b0;
            DATA:    serial_out_d = next_byte[bit_idx_d];
            STOP:    serial_out_d = 1'b1;
            default: serial_out_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and drives the line high at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            byte_idx_q   <= '0;
            frame_q      <= '0;
            serial_out_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            frame_q      <= frame_d;
            serial_out_q <= serial_out_d;
        end
    end

    assign rsp_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign serial_out = serial_out_q;

endmodule

// File: tb/tb_fpga_endpoint_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fpga_endpoint_uart_tx
//
// Bench for fpga_endpoint_uart_tx with CLKDIV = 10 and NUM_BYTES = 4.
// Expected bytes are pushed to a queue when a response is offered; a line
// monitor decodes serial_out into bytes and pops/compares them. The main
// thread checks handshake, busy and done timing.
// -----------------------------------------------------------------------------
module tb_fpga_endpoint_uart_tx;

    localparam int FREQUENCY    = 10;
    localparam int BAUD_RATE    = 1;
    localparam int NUM_BYTES    = 4;
    localparam int CLKDIV       = FREQUENCY / BAUD_RATE;
    localparam int FRAME_CYCLES = (NUM_BYTES + 1) * 10 * CLKDIV;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic        scramble;
        logic [39:0] exp_bytes;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_error;
    logic [31:0] rsp_data;
    logic        serial_out;
    logic        busy;
    logic        done;

    int          tests_run;
    int          tests_failed;
    int          rst_events;
    logic        mon_en;
    logic [7:0]  exp_q[$];
    vec_t        vecs[4];

    fpga_endpoint_uart_tx #(
        .FREQUENCY(FREQUENCY),
        .BAUD_RATE(BAUD_RATE),
        .NUM_BYTES(NUM_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_error (rsp_error),
        .rsp_data  (rsp_data),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Resets seen by the DUT; the monitor uses this to abandon a partial byte.
    initial rst_events = 0;
    always @(posedge clk) begin
        if (rst) rst_events++;
    end

    // Overall time bound so a stuck design still ends the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Line monitor: decodes each 10-bit UART character sampled at negedges,
    // checks that every bit is stable for CLKDIV cycles, and compares the
    // byte against the head of the expected queue.
    initial begin : monitor
        logic [9:0] bits;
        logic       hold_ok;
        logic       aborted;
        int         start_rst;
        logic [7:0] expv;
        wait (mon_en === 1'b1);
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0) begin
                start_rst = rst_events;
                hold_ok   = 1'b1;
                aborted   = 1'b0;
                bits      = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CLKDIV; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst_events != start_rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = serial_out;
                        else if (serial_out !== bits[b]) hold_ok = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    checkOutput("bit_hold", 32'(hold_ok), 32'd1);
                    checkOutput("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", bits[8:1], $time);
                    end else begin
                        expv = exp_q.pop_front();
                        checkOutput("line_byte", 32'(bits[8:1]), 32'(expv));
                    end
                end
            end
        end
    end

    // Offer one response (called just after a negedge while idle), then watch
    // the whole frame: busy high, ready low, done exactly on the last cycle.
    task automatic applyStimulus(input vec_t v);
        int wait_cyc;
        int busy_err;
        int ready_err;
        int done_cnt;
        int done_at;
        wait_cyc = 0;
        while (rsp_ready !== 1'b1 && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
        end
        checkOutput("ready_before_accept", 32'(rsp_ready), 32'd1);
        if (rsp_ready !== 1'b1) return;

        rsp_valid = 1'b1;
        rsp_error = v.err;
        rsp_data  = v.data;
        for (int i = 0; i <= NUM_BYTES; i++) exp_q.push_back(v.exp_bytes[i*8 +: 8]);

        busy_err  = 0;
        ready_err = 0;
        done_cnt  = 0;
        done_at   = 0;
        for (int cyc = 1; cyc <= FRAME_CYCLES; cyc++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (v.scramble && cyc == 123) begin
                rsp_data  = ~v.data;
                rsp_error = ~v.err;
            end
            if (busy !== 1'b1) busy_err++;
            if (rsp_ready !== 1'b0) ready_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
        end
        checkOutput("frame_busy_low_cycles", 32'(busy_err), 32'd0);
        checkOutput("frame_ready_high_cycles", 32'(ready_err), 32'd0);
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("done_cycle", 32'(done_at), 32'(FRAME_CYCLES));

        @(negedge clk);
        checkOutput("after_busy", 32'(busy), 32'd0);
        checkOutput("after_ready", 32'(rsp_ready), 32'd1);
        checkOutput("after_serial", 32'(serial_out), 32'd1);
        checkOutput("after_done", 32'(done), 32'd0);
        checkOutput("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int errs;
        int done_cnt;
        int ready_err;
        int d1;
        int d2;

        tests_run    = 0;
        tests_failed = 0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        rsp_valid    = 1'b0;
        rsp_error    = 1'b0;
        rsp_data     = '0;

        vecs[0] = '{err: 1'b0, data: 32'hDEADBEEF, scramble: 1'b0, exp_bytes: 40'hDE_AD_BE_EF_00};
        vecs[1] = '{err: 1'b1, data: 32'h00000000, scramble: 1'b0, exp_bytes: 40'h00_00_00_00_01};
        vecs[2] = '{err: 1'b0, data: 32'h5A3C0FF0, scramble: 1'b1, exp_bytes: 40'h5A_3C_0F_F0_00};
        vecs[3] = '{err: 1'b1, data: 32'hFFFFFFFF, scramble: 1'b1, exp_bytes: 40'hFF_FF_FF_FF_01};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_serial", 32'(serial_out), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ready", 32'(rsp_ready), 32'd1);
        mon_en = 1'b1;

        // Long idle with no request: line high, ready high, no done.
        errs = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || rsp_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) errs++;
        end
        checkOutput("idle_1000_errors", 32'(errs), 32'd0);

        // Table of single frames (ok, error, and data changed mid-frame).
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        // rsp_valid held high across two frames: one idle cycle between them.
        rsp_valid = 1'b1;
        rsp_error = 1'b0;
        rsp_data  = 32'h01234567;
        exp_q.push_back(8'h00); exp_q.push_back(8'h67); exp_q.push_back(8'h45);
        exp_q.push_back(8'h23); exp_q.push_back(8'h01);
        done_cnt  = 0;
        ready_err = 0;
        d1 = 0;
        d2 = 0;
        for (int cyc = 1; cyc <= 2 * FRAME_CYCLES + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                rsp_data = 32'h89ABCDEF;
                exp_q.push_back(8'h00); exp_q.push_back(8'hEF); exp_q.push_back(8'hCD);
                exp_q.push_back(8'hAB); exp_q.push_back(8'h89);
            end
            if (cyc == FRAME_CYCLES + 1) begin
                checkOutput("gap_ready", 32'(rsp_ready), 32'd1);
                checkOutput("gap_serial", 32'(serial_out), 32'd1);
                checkOutput("gap_busy", 32'(busy), 32'd0);
            end else if (rsp_ready !== 1'b0) begin
                ready_err++;
            end
            if (cyc == FRAME_CYCLES + 2) begin
                rsp_valid = 1'b0;
                checkOutput("second_start_bit", 32'(serial_out), 32'd0);
                checkOutput("second_busy", 32'(busy), 32'd1);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) d1 = cyc;
                else d2 = cyc;
            end
        end
        checkOutput("b2b_ready_in_frame", 32'(ready_err), 32'd0);
        checkOutput("b2b_done_count", 32'(done_cnt), 32'd2);
        checkOutput("b2b_first_done", 32'(d1), 32'(FRAME_CYCLES));
        checkOutput("b2b_second_done", 32'(d2), 32'(2 * FRAME_CYCLES + 1));
        errs = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (busy !== 1'b0 || serial_out !== 1'b1) errs++;
        end
        checkOutput("b2b_no_third_frame", 32'(errs), 32'd0);
        checkOutput("b2b_bytes_outstanding", 32'(exp_q.size()), 32'd0);

        // Reset during byte 2, bit 3 (cycles 241..250 of the frame).
        rsp_valid = 1'b1;
        rsp_error = 1'b0;
        rsp_data  = 32'hCAFEF00D;
        exp_q.push_back(8'h00); exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 245; cyc++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("pre_reset_bit3", 32'(serial_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checkOutput("abort_serial", 32'(serial_out), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(rsp_ready), 32'd1);
        errs = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done === 1'b1) done_cnt++;
            if (serial_out !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort_idle_errors", 32'(errs), 32'd0);
        applyStimulus(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
